// File: rtl/chinx_pkg.sv
// chinx_pkg: memory operand encodings, LSU state type and alignment helpers
// shared by the load/store unit and its bench.
package chinx_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int MEM_OPND_WIDTH = 3;

    localparam logic [MEM_OPND_WIDTH-1:0] MEM_OPND_BYTE  = 3'd0;
    localparam logic [MEM_OPND_WIDTH-1:0] MEM_OPND_BYTEU = 3'd1;
    localparam logic [MEM_OPND_WIDTH-1:0] MEM_OPND_HALF  = 3'd2;
    localparam logic [MEM_OPND_WIDTH-1:0] MEM_OPND_HALFU = 3'd3;
    localparam logic [MEM_OPND_WIDTH-1:0] MEM_OPND_WORD  = 3'd4;
    localparam logic [MEM_OPND_WIDTH-1:0] MEM_OPND_SETIO = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [MEM_OPND_WIDTH-1:0] opnd,
                                           input logic [1:0]                addr_lo);
        case (opnd)
            MEM_OPND_HALF, MEM_OPND_HALFU: return addr_lo[0];
            MEM_OPND_WORD:                 return (addr_lo != 2'b00);
            default:                       return 1'b0;
        endcase
    endfunction

    // Number of memory beats an access needs: 1 when aligned, else one per byte.
    function automatic logic [2:0] beat_count(input logic [MEM_OPND_WIDTH-1:0] opnd,
                                              input logic [1:0]                addr_lo);
        if (!is_misaligned(opnd, addr_lo)) begin
            return 3'd1;
        end
        return (opnd == MEM_OPND_WORD) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/chinx_lsu_if.sv
// CPU-side request/response bundle and memory-side beat bundle of the LSU.
interface chinx_lsu_if
    import chinx_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
);
    logic                      req_i;
    logic                      we_i;
    logic [MEM_OPND_WIDTH-1:0] opnd_i;
    logic [ADDR_W-1:0]         addr_i;
    logic [DATA_W-1:0]         wdata_i;
    logic                      busy_o;
    logic                      done_o;
    logic                      err_o;
    logic [DATA_W-1:0]         rdata_o;

    modport master (output req_i, we_i, opnd_i, addr_i, wdata_i,
                    input  busy_o, done_o, err_o, rdata_o);
    modport slave  (input  req_i, we_i, opnd_i, addr_i, wdata_i,
                    output busy_o, done_o, err_o, rdata_o);
endinterface

interface chinx_mem_if
    import chinx_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
);
    logic                      mem_ce_o;
    logic                      mem_we_o;
    logic [MEM_OPND_WIDTH-1:0] mem_opnd_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [DATA_W-1:0]         mem_data_o;
    logic [DATA_W-1:0]         mem_data_i;

    modport master (output mem_ce_o, mem_we_o, mem_opnd_o, mem_addr_o, mem_data_o,
                    input  mem_data_i);
    modport slave  (input  mem_ce_o, mem_we_o, mem_opnd_o, mem_addr_o, mem_data_o,
                    output mem_data_i);
endinterface

// File: rtl/chinx_lsu_merge.sv
// chinx_lsu_merge: drops one returned byte into its lane of the split-load
// buffer and produces the extended HALF/HALFU/WORD result from the new buffer.
module chinx_lsu_merge
    import chinx_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic [DATA_W-1:0]         buf_i,
    input  logic [1:0]                lane_i,
    input  logic [7:0]                byte_i,
    input  logic [MEM_OPND_WIDTH-1:0] opnd_i,
    output logic [DATA_W-1:0]         buf_o,
    output logic [DATA_W-1:0]         result_o
);
    logic [DATA_W-1:0] half_sext;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
            assign buf_o[8*gi +: 8] = (lane_i == 2'(gi)) ? byte_i : buf_i[8*gi +: 8];
        end
    endgenerate

    chinx_sext16 #(.OUT_W(DATA_W)) u_sext16 (
        .a_i (buf_o[15:0]),
        .y_o (half_sext)
    );

    always_comb begin
        result_o = buf_o;
        case (opnd_i)
            MEM_OPND_HALF:  result_o = half_sext;
            MEM_OPND_HALFU: result_o = {{(DATA_W-16){1'b0}}, buf_o[15:0]};
            default:        result_o = buf_o;
        endcase
    end
endmodule

// File: rtl/chinx_sext16.sv
// chinx_sext16: sign-extends a 16-bit value to OUT_W bits.
module chinx_sext16 #(
    parameter int OUT_W = 32
) (
    input  logic [15:0]      a_i,
    output logic [OUT_W-1:0] y_o
);
    assign y_o = {{(OUT_W-16){a_i[15]}}, a_i};
endmodule

// File: rtl/chinx_lsu.sv
// chinx_lsu: load/store unit between the MEM stage and chinx_mem32. Aligned
// accesses take one beat; misaligned HALF/WORD accesses are split into byte beats.
module chinx_lsu
    import chinx_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    chinx_lsu_if.slave  cpu,
    chinx_mem_if.master mem
);
    lsu_state_t                state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic                      we_q, we_d;
    logic                      mis_q, mis_d;
    logic                      err_q, err_d;
    logic [MEM_OPND_WIDTH-1:0] opnd_q, opnd_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [DATA_W-1:0]         buf_q, buf_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;

    logic                      req_mis;
    logic                      req_io_err;
    logic [2:0]                req_beats;
    logic [3:0]                io_hit;
    logic [1:0]                last_idx;
    logic [DATA_W-1:0]         merge_buf;
    logic [DATA_W-1:0]         merge_res;
    logic                      accept;
    logic                      busy;
    logic                      done;

    assign req_mis   = is_misaligned(cpu.opnd_i, cpu.addr_i[1:0]);
    assign req_beats = beat_count(cpu.opnd_i, cpu.addr_i[1:0]);
    assign last_idx  = 2'(beat_count(opnd_q, addr_q[1:0]) - 3'd1);

    // The low address byte alone decides the IO window; its 8-bit sum wraps like the full address.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_io
            assign io_hit[gi] = (((cpu.addr_i[7:0] + 8'(gi)) & 8'hFC) == 8'h00)
                                && (3'(gi) < req_beats);
        end
    endgenerate

    assign req_io_err = req_mis && (|io_hit);

    chinx_lsu_merge #(.DATA_W(DATA_W)) u_merge (
        .buf_i    (buf_q),
        .lane_i   (cnt_q),
        .byte_i   (mem.mem_data_i[7:0]),
        .opnd_i   (opnd_q),
        .buf_o    (merge_buf),
        .result_o (merge_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mis_d   = mis_q;
        err_d   = err_q;
        opnd_d  = opnd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        mem.mem_ce_o   = 1'b0;
        mem.mem_we_o   = 1'b0;
        mem.mem_opnd_o = MEM_OPND_WORD;
        mem.mem_addr_o = '0;
        mem.mem_data_o = '0;

        case (state_q)
            IDLE: begin
                accept = cpu.req_i;
            end
            ISSUE: begin
                busy         = 1'b1;
                mem.mem_ce_o = 1'b1;
                mem.mem_we_o = we_q;
                if (mis_q) begin
                    mem.mem_opnd_o = we_q ? MEM_OPND_BYTE : MEM_OPND_BYTEU;
                    mem.mem_addr_o = addr_q + ADDR_W'(cnt_q);
                    mem.mem_data_o = {{(DATA_W-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
                    if (!we_q) begin
                        buf_d = merge_buf;
                    end
                end else begin
                    mem.mem_opnd_o = opnd_q;
                    mem.mem_addr_o = addr_q;
                    mem.mem_data_o = wdata_q;
                end
                if (cnt_q == last_idx) begin
                    state_d = DONE;
                    cnt_d   = 2'd0;
                    if (!we_q) begin
                        rdata_d = mis_q ? merge_res : mem.mem_data_i;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                accept  = cpu.req_i;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // DONE accepts a new request exactly like IDLE, giving back-to-back issue.
        if (accept) begin
            we_d    = cpu.we_i;
            opnd_d  = cpu.opnd_i;
            addr_d  = cpu.addr_i;
            wdata_d = cpu.wdata_i;
            mis_d   = req_mis;
            err_d   = req_io_err;
            cnt_d   = 2'd0;
            if (req_io_err) begin
                state_d = DONE;
                rdata_d = '0;
            end else begin
                state_d = ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            opnd_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            opnd_q  <= opnd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

    assign cpu.busy_o  = busy;
    assign cpu.done_o  = done;
    assign cpu.err_o   = done & err_q;
    assign cpu.rdata_o = rdata_q;

endmodule

// File: tb/tb_chinx_lsu.sv
// tb_chinx_lsu: drives chinx_lsu against a byte-array memory and checks results
// against a byte-level reference model of loads, stores, splitting and the IO guard.
module tb_chinx_lsu;
    import chinx_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chinx_lsu_if cpu_if ();
    chinx_mem_if mem_if ();

    chinx_lsu u_dut (
        .clk (clk),
        .rst (rst),
        .cpu (cpu_if.slave),
        .mem (mem_if.master)
    );

    int n_vec = 0;
    int n_mis = 0;

    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] ref_rdata;
    logic        init_en;
    logic        poke_en;
    logic [9:0]  poke_addr;
    logic [7:0]  poke_data;
    logic [9:0]  ra;

    logic [31:0] beat_addr_q [$];
    logic [2:0]  beat_opnd_q [$];
    logic [31:0] beat_data_q [$];

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 73 + 41) ^ (i >> 3));
    endfunction

    // Environment memory: combinational read, write at the edge ending a beat.
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i);
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_if.mem_ce_o && mem_if.mem_we_o) begin
            case (mem_if.mem_opnd_o)
                MEM_OPND_BYTE, MEM_OPND_BYTEU: begin
                    mem[mem_if.mem_addr_o[9:0]] <= mem_if.mem_data_o[7:0];
                end
                MEM_OPND_HALF, MEM_OPND_HALFU: begin
                    mem[mem_if.mem_addr_o[9:0]]         <= mem_if.mem_data_o[7:0];
                    mem[mem_if.mem_addr_o[9:0] + 10'd1] <= mem_if.mem_data_o[15:8];
                end
                MEM_OPND_WORD: begin
                    mem[mem_if.mem_addr_o[9:0]]         <= mem_if.mem_data_o[7:0];
                    mem[mem_if.mem_addr_o[9:0] + 10'd1] <= mem_if.mem_data_o[15:8];
                    mem[mem_if.mem_addr_o[9:0] + 10'd2] <= mem_if.mem_data_o[23:16];
                    mem[mem_if.mem_addr_o[9:0] + 10'd3] <= mem_if.mem_data_o[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ra = mem_if.mem_addr_o[9:0];
        mem_if.mem_data_i = 32'h0;
        case (mem_if.mem_opnd_o)
            MEM_OPND_BYTE:  mem_if.mem_data_i = {{24{mem[ra][7]}}, mem[ra]};
            MEM_OPND_BYTEU: mem_if.mem_data_i = {24'h0, mem[ra]};
            MEM_OPND_HALF:  mem_if.mem_data_i = {{16{mem[ra+10'd1][7]}}, mem[ra+10'd1], mem[ra]};
            MEM_OPND_HALFU: mem_if.mem_data_i = {16'h0, mem[ra+10'd1], mem[ra]};
            MEM_OPND_WORD:  mem_if.mem_data_i = {mem[ra+10'd3], mem[ra+10'd2], mem[ra+10'd1], mem[ra]};
            default:        mem_if.mem_data_i = 32'h0;
        endcase
    end

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] opnd);
        if (opnd == MEM_OPND_WORD) return 4;
        if (opnd == MEM_OPND_HALF || opnd == MEM_OPND_HALFU) return 2;
        return 1;
    endfunction

    function automatic logic ref_mis(input logic [2:0] opnd, input logic [31:0] addr);
        return (ref_size(opnd) == 2 && addr % 2 != 0) || (ref_size(opnd) == 4 && addr % 4 != 0);
    endfunction

    function automatic logic ref_ioerr(input logic [2:0] opnd, input logic [31:0] addr);
        logic [31:0] a;
        if (!ref_mis(opnd, addr)) return 1'b0;
        for (int i = 0; i < ref_size(opnd); i++) begin
            a = addr + 32'(i);
            if ((a / 4) % 64 == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] opnd, input logic [31:0] addr);
        logic [31:0] v;
        logic [31:0] a;
        v = 32'h0;
        for (int i = 0; i < ref_size(opnd); i++) begin
            a = addr + 32'(i);
            v = v | (32'(ref_mem[a[9:0]]) << (8 * i));
        end
        if (opnd == MEM_OPND_BYTE && v[7])  v = v | 32'hFFFF_FF00;
        if (opnd == MEM_OPND_HALF && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] opnd, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] a;
        for (int i = 0; i < ref_size(opnd); i++) begin
            a = addr + 32'(i);
            ref_mem[a[9:0]] = 8'(wdata >> (8 * i));
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a[9:0]; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
        ref_mem[a[9:0]] = d;
    endtask

    // Issues one request from a point where the DUT is IDLE or DONE and
    // collects beats until done_o; lat counts cycles from accept (99 = timeout).
    task automatic do_access(input logic we, input logic [2:0] opnd, input logic [31:0] addr,
                             input logic [31:0] wdata, output int lat, output logic err,
                             output logic [31:0] rdata, output int nbeats);
        beat_addr_q.delete(); beat_opnd_q.delete(); beat_data_q.delete();
        cpu_if.req_i = 1'b1; cpu_if.we_i = we; cpu_if.opnd_i = opnd;
        cpu_if.addr_i = addr; cpu_if.wdata_i = wdata;
        @(posedge clk); #1;
        cpu_if.req_i = 1'b0;
        lat = 1; err = 1'b0; rdata = 32'h0;
        forever begin
            if (mem_if.mem_ce_o) begin
                beat_addr_q.push_back(mem_if.mem_addr_o);
                beat_opnd_q.push_back(mem_if.mem_opnd_o);
                beat_data_q.push_back(mem_if.mem_data_o);
            end
            if (cpu_if.done_o) begin
                err = cpu_if.err_o; rdata = cpu_if.rdata_o;
                break;
            end
            if (lat >= 20) begin lat = 99; break; end
            @(posedge clk); #1;
            lat++;
        end
        nbeats = beat_addr_q.size();
        $display("txn we=%0b opnd=%0d addr=%08h wdata=%08h lat=%0d beats=%0d err=%0b rdata=%08h",
                 we, opnd, addr, wdata, lat, nbeats, err, rdata);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; init_en = 1'b1;
        @(posedge clk); #1;
        init_en = 1'b0;
        n_vec++;
        if ({cpu_if.busy_o, cpu_if.done_o, cpu_if.err_o, mem_if.mem_ce_o, mem_if.mem_we_o} !== 5'b0) begin
            n_mis++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {cpu_if.busy_o, cpu_if.done_o, cpu_if.err_o, mem_if.mem_ce_o, mem_if.mem_we_o});
        end
        n_vec++;
        if ({cpu_if.rdata_o, mem_if.mem_addr_o, mem_if.mem_data_o} !== 96'h0) begin
            n_mis++;
            $display("FAIL reset_data: rdata=%h addr=%h data=%h want all zero",
                     cpu_if.rdata_o, mem_if.mem_addr_o, mem_if.mem_data_o);
        end
        n_vec++;
        if (mem_if.mem_opnd_o !== MEM_OPND_WORD) begin
            n_mis++;
            $display("FAIL reset_opnd: got %0d want %0d", mem_if.mem_opnd_o, MEM_OPND_WORD);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        ref_rdata = 32'h0;
    endtask

    task automatic test_aligned_load();
        int lat, nb; logic err; logic [31:0] rd;
        poke(32'h40, 8'hEF); poke(32'h41, 8'hBE); poke(32'h42, 8'hAD); poke(32'h43, 8'hDE);
        do_access(1'b0, MEM_OPND_WORD, 32'h40, 32'h0, lat, err, rd, nb);
        n_vec++;
        if (lat !== 2 || nb !== 1 || err !== 1'b0) begin
            n_mis++; $display("FAIL aligned_timing: lat=%0d beats=%0d err=%0b want 2 1 0", lat, nb, err);
        end
        n_vec++;
        if (nb == 1 && (beat_opnd_q[0] !== MEM_OPND_WORD || beat_addr_q[0] !== 32'h40)) begin
            n_mis++; $display("FAIL aligned_beat: opnd=%0d addr=%h want 4 00000040", beat_opnd_q[0], beat_addr_q[0]);
        end
        n_vec++;
        if (rd !== 32'hDEADBEEF) begin
            n_mis++; $display("FAIL aligned_rdata: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_misaligned_load();
        int lat, nb, bad; logic err; logic [31:0] rd;
        poke(32'h41, 8'h11); poke(32'h42, 8'h22); poke(32'h43, 8'h33); poke(32'h44, 8'h44);
        do_access(1'b0, MEM_OPND_WORD, 32'h41, 32'h0, lat, err, rd, nb);
        bad = 0;
        for (int i = 0; i < nb; i++)
            if (beat_addr_q[i] !== 32'h41 + 32'(i) || beat_opnd_q[i] !== MEM_OPND_BYTEU) bad++;
        n_vec++;
        if (lat !== 5 || nb !== 4 || bad != 0) begin
            n_mis++; $display("FAIL mis_word_beats: lat=%0d beats=%0d badbeats=%0d want 5 4 0", lat, nb, bad);
        end
        n_vec++;
        if (rd !== 32'h44332211) begin
            n_mis++; $display("FAIL mis_word_rdata: got %h want 44332211", rd);
        end
        poke(32'h47, 8'h80); poke(32'h48, 8'hFF);
        do_access(1'b0, MEM_OPND_HALF, 32'h47, 32'h0, lat, err, rd, nb);
        n_vec++;
        if (rd !== 32'hFFFFFF80 || lat !== 3 || nb !== 2) begin
            n_mis++; $display("FAIL mis_half: rdata=%h lat=%0d beats=%0d want ffffff80 3 2", rd, lat, nb);
        end
        do_access(1'b0, MEM_OPND_HALFU, 32'h47, 32'h0, lat, err, rd, nb);
        n_vec++;
        if (rd !== 32'h0000FF80 || lat !== 3) begin
            n_mis++; $display("FAIL mis_halfu: rdata=%h lat=%0d want 0000ff80 3", rd, lat);
        end
        ref_rdata = 32'h0000FF80;
    endtask

    task automatic test_misaligned_store();
        int lat, nb, bad; logic err; logic [31:0] rd; logic [7:0] old57;
        logic [7:0] exp_b [4];
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        old57 = ref_mem[10'h57];
        do_access(1'b1, MEM_OPND_WORD, 32'h53, 32'hA1B2C3D4, lat, err, rd, nb);
        ref_store(MEM_OPND_WORD, 32'h53, 32'hA1B2C3D4);
        bad = 0;
        for (int i = 0; i < nb; i++)
            if (beat_addr_q[i] !== 32'h53 + 32'(i) || beat_opnd_q[i] !== MEM_OPND_BYTE
                || beat_data_q[i] !== {24'h0, exp_b[i]}) bad++;
        n_vec++;
        if (nb !== 4 || bad != 0 || lat !== 5) begin
            n_mis++; $display("FAIL mis_store_beats: beats=%0d badbeats=%0d lat=%0d want 4 0 5", nb, bad, lat);
        end
        n_vec++;
        if (rd !== ref_rdata) begin
            n_mis++; $display("FAIL mis_store_rdata_held: got %h want %h", rd, ref_rdata);
        end
        do_access(1'b0, MEM_OPND_WORD, 32'h54, 32'h0, lat, err, rd, nb);
        n_vec++;
        if (rd !== {old57, 8'hA1, 8'hB2, 8'hC3}) begin
            n_mis++; $display("FAIL mis_store_readback: got %h want %h", rd, {old57, 8'hA1, 8'hB2, 8'hC3});
        end
        ref_rdata = {old57, 8'hA1, 8'hB2, 8'hC3};
    endtask

    task automatic test_io_guard();
        int lat, nb; logic err; logic [31:0] rd;
        do_access(1'b0, MEM_OPND_HALF, 32'h03, 32'h0, lat, err, rd, nb);
        n_vec++;
        if (lat !== 1 || nb !== 0 || err !== 1'b1 || rd !== 32'h0) begin
            n_mis++; $display("FAIL io_half03: lat=%0d beats=%0d err=%0b rdata=%h want 1 0 1 0", lat, nb, err, rd);
        end
        do_access(1'b0, MEM_OPND_WORD, 32'hFFFF_FFFE, 32'h0, lat, err, rd, nb);
        n_vec++;
        if (lat !== 1 || nb !== 0 || err !== 1'b1) begin
            n_mis++; $display("FAIL io_wrap: lat=%0d beats=%0d err=%0b want 1 0 1", lat, nb, err);
        end
        do_access(1'b0, MEM_OPND_WORD, 32'hFD, 32'h0, lat, err, rd, nb);
        n_vec++;
        if (err !== 1'b1 || nb !== 0) begin
            n_mis++; $display("FAIL io_last_beat: err=%0b beats=%0d want 1 0", err, nb);
        end
        do_access(1'b0, MEM_OPND_WORD, 32'h00, 32'h0, lat, err, rd, nb);
        n_vec++;
        if (err !== 1'b0 || lat !== 2 || rd !== ref_load(MEM_OPND_WORD, 32'h00)) begin
            n_mis++; $display("FAIL io_aligned_ok: err=%0b lat=%0d rdata=%h want 0 2 %h",
                              err, lat, rd, ref_load(MEM_OPND_WORD, 32'h00));
        end
        ref_rdata = ref_load(MEM_OPND_WORD, 32'h00);
    endtask

    task automatic test_reset_mid_split();
        int lat, nb, bad; logic err; logic [31:0] rd;
        cpu_if.req_i = 1'b1; cpu_if.we_i = 1'b1; cpu_if.opnd_i = MEM_OPND_WORD;
        cpu_if.addr_i = 32'h61; cpu_if.wdata_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        cpu_if.req_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++;
        if (mem_if.mem_ce_o !== 1'b1 || mem_if.mem_addr_o !== 32'h63) begin
            n_mis++; $display("FAIL split_beat2: ce=%0b addr=%h want 1 00000063", mem_if.mem_ce_o, mem_if.mem_addr_o);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (mem_if.mem_ce_o !== 1'b0 || cpu_if.done_o !== 1'b0 || cpu_if.busy_o !== 1'b0) begin
            n_mis++; $display("FAIL split_abort: ce=%0b done=%0b busy=%0b want 0 0 0",
                              mem_if.mem_ce_o, cpu_if.done_o, cpu_if.busy_o);
        end
        @(posedge clk); #1;
        n_vec++;
        if (cpu_if.done_o !== 1'b0 || mem_if.mem_ce_o !== 1'b0) begin
            n_mis++; $display("FAIL split_no_done: done=%0b ce=%0b want 0 0", cpu_if.done_o, mem_if.mem_ce_o);
        end
        rst = 1'b1;
        ref_mem[10'h61] = 8'h0D;
        ref_mem[10'h62] = 8'hF0;
        bad = 0;
        for (int i = 'h61; i <= 'h64; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_vec++;
        if (bad != 0) begin
            n_mis++; $display("FAIL split_partial_mem: got %h %h %h %h want %h %h %h %h",
                              mem['h61], mem['h62], mem['h63], mem['h64],
                              ref_mem['h61], ref_mem['h62], ref_mem['h63], ref_mem['h64]);
        end
        do_access(1'b0, MEM_OPND_WORD, 32'h60, 32'h0, lat, err, rd, nb);
        n_vec++;
        if (lat !== 2 || rd !== ref_load(MEM_OPND_WORD, 32'h60)) begin
            n_mis++; $display("FAIL split_recover: lat=%0d rdata=%h want 2 %h", lat, rd, ref_load(MEM_OPND_WORD, 32'h60));
        end
        ref_rdata = ref_load(MEM_OPND_WORD, 32'h60);
    endtask

    task automatic test_back_to_back();
        int lat, nb, bad; logic err; logic [31:0] rd, a; time t0;
        bad = 0;
        t0 = $time;
        for (int k = 0; k < 6; k++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            do_access(1'b0, MEM_OPND_WORD, a, 32'h0, lat, err, rd, nb);
            if (lat !== 2 || rd !== ref_load(MEM_OPND_WORD, a)) bad++;
            ref_rdata = ref_load(MEM_OPND_WORD, a);
        end
        n_vec++;
        if (bad != 0) begin
            n_mis++; $display("FAIL b2b_results: %0d of 6 accesses wrong", bad);
        end
        n_vec++;
        if ($time - t0 !== 120) begin
            n_mis++; $display("FAIL b2b_throughput: elapsed %0t want 120", $time - t0);
        end
    endtask

    task automatic test_random(input int n);
        int lat, nb, bad, exp_lat, exp_nb, sz;
        logic err, we, mis, ioe; logic [31:0] rd, a, wd, exp_rd;
        logic [2:0] op;
        for (int k = 0; k < n; k++) begin
            we = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 4));
            a  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                             : 32'($urandom_range(0, 1023));
            wd = $urandom;
            if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
            sz  = ref_size(op);
            mis = ref_mis(op, a);
            ioe = ref_ioerr(op, a);
            exp_lat = ioe ? 1 : (mis ? sz + 1 : 2);
            exp_nb  = ioe ? 0 : (mis ? sz : 1);
            exp_rd  = ioe ? 32'h0 : (we ? ref_rdata : ref_load(op, a));
            do_access(we, op, a, wd, lat, err, rd, nb);
            if (we && !ioe) ref_store(op, a, wd);
            ref_rdata = exp_rd;
            bad = 0;
            for (int i = 0; i < nb; i++) if (beat_addr_q[i] !== a + (mis ? 32'(i) : 32'h0)) bad++;
            n_vec++;
            if (lat !== exp_lat || nb !== exp_nb || bad != 0) begin
                n_mis++; $display("FAIL rnd_timing[%0d]: lat=%0d beats=%0d badaddr=%0d want %0d %0d 0",
                                  k, lat, nb, bad, exp_lat, exp_nb);
            end
            n_vec++;
            if (err !== ioe || rd !== exp_rd) begin
                n_mis++; $display("FAIL rnd_result[%0d]: err=%0b rdata=%h want %0b %h", k, err, rd, ioe, exp_rd);
            end
            if (we) begin
                bad = 0;
                for (int i = 0; i < sz; i++) if (mem[10'(a + 32'(i))] !== ref_mem[10'(a + 32'(i))]) bad++;
                n_vec++;
                if (bad != 0) begin
                    n_mis++; $display("FAIL rnd_mem[%0d]: %0d of %0d bytes differ at %h", k, bad, sz, a);
                end
            end
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_vec++;
        if (bad != 0) begin
            n_mis++; $display("FAIL rnd_mem_final: %0d bytes differ", bad);
        end
    endtask

    initial begin
        rst = 1'b0; init_en = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        cpu_if.req_i = 1'b0; cpu_if.we_i = 1'b0; cpu_if.opnd_i = MEM_OPND_WORD;
        cpu_if.addr_i = '0; cpu_if.wdata_i = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
        ref_rdata = 32'h0;
        test_reset();
        test_aligned_load();
        test_misaligned_load();
        test_misaligned_store();
        test_io_guard();
        test_reset_mid_split();
        test_back_to_back();
        test_random(60);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/chinx_lsu.md
# chinx_lsu

Load/store unit sitting between the CPU MEM stage and `chinx_mem32`; it acts as the initiator on the memory-side `ce/opnd/addr/data` interface. Aligned accesses go to memory as one beat. Misaligned HALF/HALFU/WORD accesses are split into little-endian BYTEU/BYTE beats, and the read result is reassembled and extended. The MEM stage stalls on `busy_o` and takes results on the `done_o` pulse.

## Interface
Parameters:
- `ADDR_W`, default `ADDR_WIDTH`: address width.
- `DATA_W`, default `DATA_WIDTH` (32): data width.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req_i`  in  1: access request, sampled only when `busy_o`=0.
- `we_i`  in  1: 1=store, 0=load.
- `opnd_i`  in  `MEM_OPND_WIDTH`: BYTE/BYTEU/HALF/HALFU/WORD/SETIO.
- `addr_i`  in  `ADDR_W`: byte address.
- `wdata_i`  in  `DATA_W`: store data, right-aligned.
- `busy_o`  out  1: request in flight; upstream holds.
- `done_o`  out  1: one-cycle completion pulse.
- `err_o`  out  1: valid with `done_o`; access rejected.
- `rdata_o`  out  `DATA_W`: load result, registered, valid with `done_o`, held until next `done_o`.
- `mem_ce_o`  out  1: beat strobe to memory.
- `mem_opnd_o`  out  `MEM_OPND_WIDTH`: beat operand.
- `mem_addr_o`  out  `ADDR_W`: beat address.
- `mem_data_o`  out  `DATA_W`: beat write data.
- `mem_data_i`  in  `DATA_W`: combinational read data from memory, same cycle as beat.

## Operation
- Misaligned means HALF/HALFU with `addr[0]`=1, or WORD with `addr[1:0]`≠0. BYTE, BYTEU and SETIO are never misaligned.
- Aligned access: one beat; `mem_opnd_o`=`opnd_i`, `mem_addr_o`=`addr_i`, `mem_data_o`=`wdata_i`. A load captures `mem_data_i` unchanged into `rdata_o`.
- Misaligned access: k beats (k=2 HALF*, k=4 WORD). Beat i has address `addr_i`+i, modulo 2^ADDR_W.
  - Loads issue BYTEU beats; the captured `mem_data_i[7:0]` goes to `buf[8i+7:8i]`.
  - Stores issue BYTE beats with `mem_data_o` = {24'b0, `wdata_i[8i+7:8i]`}.
- Final misaligned load result: HALF sign-extends `buf[15:0]`; HALFU zero-extends it; WORD returns `buf` unchanged.
- IO guard: a misaligned access where any beat has `addr[7:2]`=0 (IO window) issues no beats; it completes with `err_o`=1 and `rdata_o`=0.
- Store completions leave `rdata_o` at its previous value.
- FSM states:
  - IDLE: `busy_o`=0. On `req_i`, capture the request and go to ISSUE, or to DONE for an IO-guard error.
  - ISSUE: `busy_o`=1, `mem_ce_o`=1, beat counter increments each cycle. After the last beat, go to DONE.
  - DONE: `done_o`=1, `busy_o`=0. A `req_i` here is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- Outside ISSUE: `mem_ce_o`=0, `mem_opnd_o`=`MEM_OPND_WORD`, `mem_addr_o`=0, `mem_data_o`=0.

## Timing
- Request accepted at the edge ending cycle N; beats occur in cycles N+1..N+k; `done_o` in cycle N+k+1.
- Latency: aligned access 2 cycles, misaligned HALF 3, misaligned WORD 5, IO-guard error 1 (`done_o` in N+1).
- Memory writes commit at the edge ending each beat cycle. Read data is captured at that same edge.
- Back-to-back throughput: one aligned access per 2 cycles.
- Reset (`rst`=0, async): state IDLE, beat counter 0, all outputs 0, except `mem_opnd_o`=`MEM_OPND_WORD`.
- Reset mid-split aborts immediately: `mem_ce_o` drops without waiting for the clock, no `done_o` is produced, and bytes already stored remain in memory.
- Address wrap: a split at 0xFFFF_FFFE proceeds to 0x0000_0000. That address is in the IO window, so the IO guard rejects the access.

## Structure
- Shared package `chinx_pkg`:
  - `lsu_state_t` enum {IDLE, ISSUE, DONE};
  - function `is_misaligned(opnd, addr)`;
  - the `MEM_OPND_*` constants, migrated from `defines.vh` and kept bit-identical.
- One sub-module, `chinx_lsu_merge`: byte-lane assembly plus HALF/HALFU extension, reusing `chinx_sext16`. Everything else stays in `chinx_lsu`.

## Test plan
- Aligned word load at 0x40 (memory 0xDEADBEEF) → one beat, `mem_opnd_o`=WORD; `done_o` 2 cycles after accept; `rdata_o`=0xDEADBEEF.
- Misaligned word load at 0x41 (bytes 0x41..0x44 = 11,22,33,44) → 4 BYTEU beats at 0x41..0x44; `rdata_o`=0x44332211, `done_o` at cycle 5.
- Misaligned HALF load at 0x47 (bytes 0x80, 0xFF) → `rdata_o`=0xFFFFFF80; the same access with HALFU → 0x0000FF80.
- Misaligned word store 0xA1B2C3D4 at 0x53 → BYTE beats in order 0x53=D4, 0x54=C3, 0x55=B2, 0x56=A1; aligned readback at 0x54 then gives bytes 0x54..0x57 = C3,B2,A1,old[0x57].
- Misaligned HALF load at 0x03 → no `mem_ce_o`; `done_o`=1 and `err_o`=1 at N+1; `rdata_o`=0.
- Assert `rst`=0 during beat 2 of a 4-beat store → `mem_ce_o`=0 immediately, no `done_o`, only bytes 0 and 1 written; the next request executes normally.
